prei_md_fetch: RTL and testbench

PREI_MD_FETCH -- requirements
Module: prei_md_fetch

---
 rtl/enc_defines.sv | 9 +
 rtl/prei_md_fetch_pkg.sv | 14 +
 rtl/prei_md_fifo.sv | 59 +++++
 rtl/prei_md_fetch.sv | 167 ++++++++++++++++
 tb/tb_prei_md_fetch.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/enc_defines.sv
// Shared encoder constants for the mode-buffer address map.
//   MD_TREE_NUM : number of tree-node entries (addresses 0..83)
//   MD_ADDR_MAX : highest logical mode address (last 4x4 unit)
//   MD_WIDTH    : width of one mode value
package enc_defines;
  localparam int MD_TREE_NUM = 84;
  localparam int MD_ADDR_MAX = 339;
  localparam int MD_WIDTH    = 6;
endpackage

// File: rtl/prei_md_fetch_pkg.sv
// Types and widths local to the pre-intra mode fetch block.
//   md_fetch_state_e : job controller states
//   MD_ADDR_W        : logical mode address width
//   MD_ENTRY_W       : width of one skid-FIFO entry {mode, addr, last}
package prei_md_fetch_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } md_fetch_state_e;

  localparam int MD_ADDR_W  = 9;
  localparam int MD_ENTRY_W = enc_defines::MD_WIDTH + MD_ADDR_W + 1;
endpackage

// File: rtl/prei_md_fifo.sv
// Small synchronous skid FIFO for fetched mode entries.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset (pointers/count only)
//   push        : write push_data this cycle (caller guarantees space)
//   push_data   : entry to store
//   pop         : consume head entry (ignored when empty)
//   pop_data    : head entry, forced to zero while empty
//   not_empty   : head entry valid
module prei_md_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              not_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign pop_data  = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/prei_md_fetch.sv
// Pre-intra mode fetch: walks a range of logical mode addresses, reads the
// mode buffer (one read per 4x4 group, replaying the held mode for the rest
// of the group) and streams {mode, addr, last} through a skid FIFO.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start_i           : one-cycle job launch (honoured only when idle)
//   base_i, count_i   : first logical address and entry count of the job
//   done_o            : one-cycle pulse after the final entry is accepted
//   posi_md_ena_o     : mode-buffer read enable
//   posi_md_addr_o    : mode-buffer logical read address
//   posi_md_data_i    : read data, valid one cycle after posi_md_ena_o
//   md_valid_o/md_ready_i : output stream handshake
//   md_data_o, md_addr_o, md_last_o : mode, address tag, final-entry flag
module prei_md_fetch
  import enc_defines::*;
  import prei_md_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [MD_ADDR_W-1:0] base_i,
  input  logic [MD_ADDR_W-1:0] count_i,
  output logic                 done_o,
  output logic                 posi_md_ena_o,
  output logic [MD_ADDR_W-1:0] posi_md_addr_o,
  input  logic [MD_WIDTH-1:0]  posi_md_data_i,
  output logic                 md_valid_o,
  input  logic                 md_ready_i,
  output logic [MD_WIDTH-1:0]  md_data_o,
  output logic [MD_ADDR_W-1:0] md_addr_o,
  output logic                 md_last_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // Last address of a job, saturated at the top of the mode map.
  function automatic logic [MD_ADDR_W-1:0] sat_end(
    input logic [MD_ADDR_W-1:0] base,
    input logic [MD_ADDR_W-1:0] count
  );
    logic [MD_ADDR_W:0] sum;
    sum = {1'b0, base} + {1'b0, count} - (MD_ADDR_W + 1)'(1);
    if (sum > (MD_ADDR_W + 1)'(MD_ADDR_MAX)) return MD_ADDR_W'(MD_ADDR_MAX);
    return sum[MD_ADDR_W-1:0];
  endfunction

  md_fetch_state_e           state;
  md_fetch_state_e           state_nxt;
  logic [MD_ADDR_W-1:0]      cur_addr_p0;
  logic [MD_ADDR_W-1:0]      end_addr;
  logic                      first_p0;
  logic                      issue_p0;
  logic                      rd_p0;
  logic                      last_p0;
  logic                      need_read_p0;
  logic [1:0]                unit_phase_p0;
  logic                      zero_job;
  logic                      has_credit;
  logic                      pop;
  logic [CNT_W-1:0]          credit;
  logic                      vld_p1;
  logic                      rd_p1;
  logic                      last_p1;
  logic [MD_ADDR_W-1:0]      addr_p1;
  logic [MD_WIDTH-1:0]       held_md;
  logic [MD_WIDTH-1:0]       push_md_p1;
  logic [MD_ENTRY_W-1:0]     fifo_dout;
  logic                      fifo_vld;

  // A job that is empty or starts past the map end completes immediately.
  assign zero_job = (count_i == '0) || (base_i > MD_ADDR_W'(MD_ADDR_MAX));

  // Position inside a 4x4 group; groups start at MD_TREE_NUM.
  assign unit_phase_p0 = 2'(cur_addr_p0 - MD_ADDR_W'(MD_TREE_NUM));
  assign need_read_p0  = (cur_addr_p0 < MD_ADDR_W'(MD_TREE_NUM)) || first_p0 ||
                         (unit_phase_p0 == 2'd0);

  assign pop = fifo_vld && md_ready_i;

  // Credits cover FIFO occupancy plus the entry in flight; a pop this cycle
  // frees a slot in time for an issue this cycle.
  assign has_credit = (credit < CNT_W'(FIFO_DEPTH)) || pop;

  always_comb begin
    state_nxt = state;
    issue_p0  = 1'b0;
    rd_p0     = 1'b0;
    last_p0   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i && !zero_job) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (has_credit) begin
          issue_p0 = 1'b1;
          rd_p0    = need_read_p0;
          last_p0  = (cur_addr_p0 == end_addr);
          if (last_p0) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && md_last_o) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign posi_md_ena_o  = issue_p0 && rd_p0;
  assign posi_md_addr_o = cur_addr_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_addr_p0 <= '0;
      end_addr    <= '0;
      first_p0    <= 1'b0;
      vld_p1      <= 1'b0;
      rd_p1       <= 1'b0;
      last_p1     <= 1'b0;
      credit      <= '0;
      done_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start_i && !zero_job) begin
        cur_addr_p0 <= base_i;
        end_addr    <= sat_end(base_i, count_i);
        first_p0    <= 1'b1;
      end else if (issue_p0) begin
        cur_addr_p0 <= cur_addr_p0 + MD_ADDR_W'(1);
        first_p0    <= 1'b0;
      end
      // ---- p0 -> p1: issued entry waits one cycle for the buffer data ----
      vld_p1  <= issue_p0;
      rd_p1   <= rd_p0;
      last_p1 <= last_p0;
      credit  <= credit + CNT_W'(issue_p0) - CNT_W'(pop);
      done_o  <= (state == ST_IDLE && start_i && zero_job) || (pop && md_last_o);
    end
  end

  always_ff @(posedge clk) begin
    addr_p1 <= cur_addr_p0;
    if (vld_p1 && rd_p1) held_md <= posi_md_data_i;
  end

  // ---- p1 -> FIFO: read data or replayed group mode enters the skid FIFO ----
  assign push_md_p1 = rd_p1 ? posi_md_data_i : held_md;

  prei_md_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (MD_ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data ({push_md_p1, addr_p1, last_p1}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .not_empty (fifo_vld)
  );

  assign md_valid_o = fifo_vld;
  assign md_data_o  = fifo_dout[MD_ENTRY_W-1 -: MD_WIDTH];
  assign md_addr_o  = fifo_dout[MD_ADDR_W:1];
  assign md_last_o  = fifo_dout[0];
endmodule

// File: tb/tb_prei_md_fetch.sv
// Directed bench for prei_md_fetch: a behavioural mode buffer answers reads
// one cycle late with mode_of(addr); expected entries, read addresses and
// timings come from the hand-written address model below.
module tb_prei_md_fetch;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [8:0] base_i;
  logic [8:0] count_i;
  logic       done_o;
  logic       posi_md_ena_o;
  logic [8:0] posi_md_addr_o;
  logic [5:0] posi_md_data_i;
  logic       md_valid_o;
  logic       md_ready_i;
  logic [5:0] md_data_o;
  logic [8:0] md_addr_o;
  logic       md_last_o;

  always #5 clk = ~clk;

  prei_md_fetch #(.FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .base_i         (base_i),
    .count_i        (count_i),
    .done_o         (done_o),
    .posi_md_ena_o  (posi_md_ena_o),
    .posi_md_addr_o (posi_md_addr_o),
    .posi_md_data_i (posi_md_data_i),
    .md_valid_o     (md_valid_o),
    .md_ready_i     (md_ready_i),
    .md_data_o      (md_data_o),
    .md_addr_o      (md_addr_o),
    .md_last_o      (md_last_o)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int job_base, job_end, exp_addr, exp_rd, n_xfer, rd_issued, rd_popped;
  int max_out, first_ena, first_vld, last_cyc, done_cyc, done_seen, start_cyc;
  bit job_active, rnd_ready, stall_prev, pend;
  logic [15:0] stall_word;
  logic [8:0]  pend_addr;

  function automatic logic [5:0] mode_of(input int a);
    return 6'((a * 7 + 3) % 64);
  endfunction

  // Address whose buffer read supplies the mode for entry a.
  function automatic int src_of(input int a, input int base);
    int s;
    if (a < 84 || a == base || ((a - 84) % 4) == 0) return a;
    s = a - ((a - 84) % 4);
    if (s < base) s = base;
    return s;
  endfunction

  function automatic bit is_read(input int a, input int base);
    return src_of(a, base) == a;
  endfunction

  function automatic int next_read(input int prev, input int base, input int last);
    int a;
    a = prev + 1;
    while (a <= last && !is_read(a, base)) a++;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_reset_values(input string pfx);
    chk({pfx, "_ena"},   posi_md_ena_o,  0);
    chk({pfx, "_raddr"}, posi_md_addr_o, 0);
    chk({pfx, "_valid"}, md_valid_o,     0);
    chk({pfx, "_data"},  md_data_o,      0);
    chk({pfx, "_addr"},  md_addr_o,      0);
    chk({pfx, "_last"},  md_last_o,      0);
    chk({pfx, "_done"},  done_o,         0);
  endtask

  // One clock: drive inputs just after the falling edge, then observe what
  // the next rising edge will act on.
  task automatic step();
    @(negedge clk);
    cyc++;
    md_ready_i     = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    posi_md_data_i = pend ? mode_of(int'(pend_addr)) : 6'h2A;
    #1;
    if (!job_active) begin
      chk("idle_valid", md_valid_o, 0);
      chk("idle_ena", posi_md_ena_o, 0);
      chk("idle_done", done_o, 0);
    end else begin
      if (stall_prev) begin
        chk("hold_valid", md_valid_o, 1);
        chk("hold_word", {md_data_o, md_addr_o, md_last_o}, stall_word);
      end
      if (done_o) begin
        if (done_seen == 0) done_cyc = cyc;
        done_seen++;
      end
      if (posi_md_ena_o) begin
        chk("rd_addr", posi_md_addr_o, exp_rd);
        if (first_ena < 0) first_ena = cyc;
        exp_rd = next_read(exp_rd, job_base, job_end);
        rd_issued++;
      end
      if (md_valid_o && first_vld < 0) first_vld = cyc;
      if (md_valid_o && md_ready_i) begin
        chk("md_addr", md_addr_o, exp_addr);
        chk("md_data", md_data_o, mode_of(src_of(exp_addr, job_base)));
        chk("md_last", md_last_o, exp_addr == job_end);
        if (is_read(exp_addr, job_base)) rd_popped++;
        if (md_last_o) last_cyc = cyc;
        exp_addr++;
        n_xfer++;
      end
      if (rd_issued - rd_popped > max_out) max_out = rd_issued - rd_popped;
      stall_prev = md_valid_o && !md_ready_i;
      stall_word = {md_data_o, md_addr_o, md_last_o};
    end
    pend      = posi_md_ena_o;
    pend_addr = posi_md_addr_o;
  endtask

  task automatic start_job(input int base, input int cnt, input int exp_n, input bit rnd);
    job_base = base; job_end = base + exp_n - 1;
    exp_addr = base; exp_rd = base;
    n_xfer = 0; rd_issued = 0; rd_popped = 0; max_out = 0;
    first_ena = -1; first_vld = -1; last_cyc = -1; done_cyc = -1; done_seen = 0;
    stall_prev = 0; rnd_ready = rnd; job_active = 1;
    start_i = 1'b1; base_i = 9'(base); count_i = 9'(cnt);
    start_cyc = cyc;
    step();
    start_i = 1'b0;
  endtask

  task automatic finish_job(input int exp_n, input int exp_reads, input bit spur);
    for (int i = 0; i < 5000 && done_seen == 0; i++) begin
      if (spur && i == 5) begin
        start_i = 1'b1; base_i = 9'd200; count_i = 9'd3;
      end else begin
        start_i = 1'b0;
      end
      step();
    end
    start_i = 1'b0;
    step();
    step();
    job_active = 0;
    rnd_ready  = 0;
    chk("done_pulses", done_seen, 1);
    chk("entries", n_xfer, exp_n);
    chk("reads", rd_issued, exp_reads);
    chk("done_cycle", done_cyc, (exp_n == 0) ? start_cyc + 1 : last_cyc + 1);
    chk("credit_bound", max_out <= 2, 1);
    if (rnd_ready == 0 && exp_n > 0 && !spur) begin
      chk("rd_to_valid", first_vld - first_ena, 2);
      chk("throughput", last_cyc - first_vld, exp_n - 1);
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; base_i = '0; count_i = '0;
    md_ready_i = 1'b1; posi_md_data_i = '0;
    pend = 0; pend_addr = '0; job_active = 0; rnd_ready = 0; stall_prev = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_values("rst");
    rst = 1'b0;
    repeat (2) step();

    // Tree nodes only: one read per entry, last on 83.
    start_job(0, 84, 84, 0);
    finish_job(84, 84, 0);

    // Aligned 4x4 groups: reads at 84 and 88 only.
    start_job(84, 8, 8, 0);
    finish_job(8, 2, 0);

    // Unaligned start: 86 read as first, 87 replays it, 88 read, 89 replays.
    start_job(86, 4, 4, 0);
    finish_job(4, 2, 0);

    // Crossing from tree nodes into units: reads 80..84 and 88.
    start_job(80, 10, 10, 0);
    finish_job(10, 6, 0);

    // Full map with random back-pressure and a start pulse during the job.
    start_job(0, 340, 340, 1);
    finish_job(340, 148, 1);

    // Empty job: done one cycle after start, no reads.
    start_job(5, 0, 0, 0);
    finish_job(0, 0, 0);

    // Clipped job ends on 339: reads 330, 332, 336.
    start_job(330, 20, 10, 0);
    finish_job(10, 3, 0);

    // Abort at entry 10, then rerun the same job.
    start_job(0, 84, 84, 0);
    for (int i = 0; i < 300 && n_xfer < 10; i++) step();
    chk("abort_point", n_xfer, 10);
    rst = 1'b1;
    #1;
    chk_reset_values("abort");
    #1;
    rst = 1'b0;
    job_active = 0;
    repeat (4) step();
    start_job(0, 84, 84, 0);
    finish_job(84, 84, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
